// File: rtl/and_out_monitor_if.sv
// Signal bundle between the AND-gate stage driver and and_out_monitor.
// The fall_o member exists only when AND_MON_FALL_EN is defined.
interface and_out_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             c_in;
    logic             clr;
    logic             level_o;
    logic             rise_o;
    logic [CNT_W-1:0] count_o;
    logic             sat_o;
`ifdef AND_MON_FALL_EN
    logic             fall_o;
`endif

    modport master (
        output c_in,
        output clr,
        input  level_o,
        input  rise_o,
        input  count_o,
        input  sat_o
`ifdef AND_MON_FALL_EN
        , input fall_o
`endif
    );

    modport slave (
        input  c_in,
        input  clr,
        output level_o,
        output rise_o,
        output count_o,
        output sat_o
`ifdef AND_MON_FALL_EN
        , output fall_o
`endif
    );
endinterface

// File: rtl/and_out_monitor.sv
// Synchronises and debounces the AND-gate output into a level, a rise pulse and a
// saturating event count. Define AND_MON_FALL_EN to add the fall_o pulse.
module and_out_monitor #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 8
) (
    input logic              clk,
    input logic              rst_n,
    and_out_monitor_if.slave mon
);
    typedef enum logic [1:0] {StLow, StRiseChk, StHigh, StFallChk} state_e;

    localparam logic [7:0] DbLast = 8'(DB_CYCLES - 1);

    logic             ff1_q, ff1_d;
    logic             sync_q, sync_d;
    state_e           state_q, state_d;
    logic [7:0]       stab_cnt_q, stab_cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        ff1_d      = mon.c_in;
        sync_d     = ff1_q;
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;

        unique case (state_q)
            StLow: begin
                if (sync_q) begin
                    state_d    = StRiseChk;
                    stab_cnt_d = 8'd1;
                end
            end
            StRiseChk: begin
                if (!sync_q) begin
                    state_d    = StLow;
                    stab_cnt_d = 8'd0;
                end else if (stab_cnt_q == DbLast) begin
                    state_d    = StHigh;
                    stab_cnt_d = 8'd0;
                    level_d    = 1'b1;
                    rise_d     = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + 8'd1;
                end
            end
            StHigh: begin
                if (!sync_q) begin
                    state_d    = StFallChk;
                    stab_cnt_d = 8'd1;
                end
            end
            StFallChk: begin
                if (sync_q) begin
                    state_d    = StHigh;
                    stab_cnt_d = 8'd0;
                end else if (stab_cnt_q == DbLast) begin
                    state_d    = StLow;
                    stab_cnt_d = 8'd0;
                    level_d    = 1'b0;
                    fall_d     = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = StLow;
                stab_cnt_d = 8'd0;
            end
        endcase

        // Clear wins over the old value but not over a rise on the same edge.
        count_d = count_q;
        if (mon.clr) begin
            count_d = rise_d ? CNT_W'(1) : '0;
        end else if (rise_d && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff1_q      <= 1'b0;
            sync_q     <= 1'b0;
            state_q    <= StLow;
            stab_cnt_q <= 8'd0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            ff1_q      <= ff1_d;
            sync_q     <= sync_d;
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            count_q    <= count_d;
        end
    end

    assign mon.level_o = level_q;
    assign mon.rise_o  = rise_q;
    assign mon.count_o = count_q;
    assign mon.sat_o   = &count_q;
`ifdef AND_MON_FALL_EN
    assign mon.fall_o  = fall_q;
`else
    logic unused_fall;
    assign unused_fall = fall_q;
`endif
endmodule

// File: tb/tb_and_out_monitor.sv
// Bench for and_out_monitor: run-length reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_and_out_monitor;
    localparam int unsigned DB    = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned MAXC  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    and_out_monitor_if #(.CNT_W(CW)) bus ();

    and_out_monitor #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (bus.slave)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: sync is a 2-sample delay of c_in; level flips once DB consecutive
    // synced samples disagree with it.
    bit m_ff1, m_sync, m_lvl, m_rise, m_fall;
    int m_run, m_cnt;

    always @(posedge clk) begin
        bit s;
        if (!rst_n) begin
            m_ff1 = 0; m_sync = 0; m_lvl = 0; m_rise = 0; m_fall = 0;
            m_run = 0; m_cnt = 0;
        end else begin
            s = m_sync;
            m_sync = m_ff1;
            m_ff1 = bus.c_in;
            m_rise = 0;
            m_fall = 0;
            if (s != m_lvl) begin
                m_run++;
                if (m_run == DB) begin
                    m_lvl = s; m_run = 0; m_rise = s; m_fall = !s;
                end
            end else begin
                m_run = 0;
            end
            if (bus.clr) m_cnt = m_rise ? 1 : 0;
            else if (m_rise && m_cnt != MAXC) m_cnt++;
        end
    end

    logic compare_en = 1'b0;
    always @(posedge clk) begin
        #1;
        if (compare_en) begin
            check("level", int'(bus.level_o), int'(m_lvl));
            check("rise", int'(bus.rise_o), int'(m_rise));
            check("count", int'(bus.count_o), m_cnt);
            check("sat", int'(bus.sat_o), int'(m_cnt == MAXC));
`ifdef AND_MON_FALL_EN
            check("fall", int'(bus.fall_o), int'(m_fall));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        bus.c_in = 1'b1; cyc(hi);
        bus.c_in = 1'b0; cyc(lo);
    endtask

    initial begin
        bus.c_in = 1'b1;
        bus.clr  = 1'b0;
        rst_n    = 1'b0;
        compare_en = 1'b1;

        // Reset with c_in high: everything stays 0.
        cyc(2);
        check("rst_level", int'(bus.level_o), 0);
        check("rst_count", int'(bus.count_o), 0);
        check("rst_rise", int'(bus.rise_o), 0);
        rst_n = 1'b1;
        // First sampling edge is k=1; level rises on edge k+DB+1 = 6.
        cyc(5);
        check("t1_level_early", int'(bus.level_o), 0);
        cyc(1);
        check("t1_level", int'(bus.level_o), 1);
        check("t1_rise", int'(bus.rise_o), 1);
        check("t1_count", int'(bus.count_o), 1);
        cyc(1);
        check("t1_rise_one_cycle", int'(bus.rise_o), 0);

        // Fall: first low sampled at edge k; level drops on edge k+5.
        bus.c_in = 1'b0;
        cyc(5);
        check("fall_level_early", int'(bus.level_o), 1);
        cyc(1);
        check("fall_level", int'(bus.level_o), 0);
`ifdef AND_MON_FALL_EN
        check("fall_pulse", int'(bus.fall_o), 1);
`endif
        cyc(4);

        // Short pulse: 3 samples high is rejected.
        pulse(3, 12);
        check("t2_level", int'(bus.level_o), 0);
        check("t2_count", int'(bus.count_o), 1);

        // Saturation.
        for (int i = 0; i < 280; i++) pulse(8, 8);
        check("t3_count_sat", int'(bus.count_o), 255);
        check("t3_sat", int'(bus.sat_o), 1);
        bus.clr = 1'b1; cyc(1); bus.clr = 1'b0;
        check("t3_clr_count", int'(bus.count_o), 0);
        check("t3_clr_sat", int'(bus.sat_o), 0);

        // Count to 3, then clear on the same edge as a rise.
        pulse(8, 8); pulse(8, 8); pulse(8, 8);
        check("t4_pre", int'(bus.count_o), 3);
        bus.c_in = 1'b1;
        cyc(5);
        bus.clr = 1'b1; cyc(1); bus.clr = 1'b0;
        check("t4_rise", int'(bus.rise_o), 1);
        check("t4_count", int'(bus.count_o), 1);
        bus.c_in = 1'b0; cyc(10);

        // Reach 7, then reset while in the rise check.
        for (int i = 0; i < 6; i++) pulse(8, 8);
        check("t5_pre", int'(bus.count_o), 7);
        bus.c_in = 1'b1;
        cyc(4);
        rst_n = 1'b0; bus.c_in = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        check("t5_count", int'(bus.count_o), 0);
        check("t5_level", int'(bus.level_o), 0);
        cyc(8);
        check("t5_no_rise_level", int'(bus.level_o), 0);
        check("t5_no_rise_count", int'(bus.count_o), 0);

        // Glitchy high: one low sample restarts qualification.
        bus.c_in = 1'b1; cyc(3); bus.c_in = 1'b0; cyc(1); bus.c_in = 1'b1; cyc(3);
        check("glitch_level", int'(bus.level_o), 0);
        cyc(4);
        check("glitch_then_high", int'(bus.level_o), 1);
        check("glitch_count", int'(bus.count_o), 1);
        bus.c_in = 1'b0; cyc(10);

        compare_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
